shift_exec_stage: RTL and testbench
===================================

Name: shift_exec_stage

Overview:
- Two-stage elastic execute stage for MIPS shift instructions: SLL, SRL, SRA, SLLV, SRLV, SRAV.
- Sits between the ID/EX operand latch (upstream) and the EX/MEM writeback path (downstream).
- Stage 1 decodes funct and selects the shift amount (shamt field or rs[4:0]).
- Stage 2 registers the 32-bit barrel-shift result.
- Uses valid/ready handshake on both sides, so backpressure from MEM stalls the stage without losing data.

Parameters:
- DW, 32, datapath width; fixed at 32 (the shift amount is 5 bits).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_funct  in  6  MIPS funct field
- in_shamt  in  5  instruction shamt field
- in_rs  in  32  rs operand (variable shift amount source)
- in_rt  in  32  rt operand (value to shift)
- in_rd  in  5  destination register
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_result  out  32  shifted value
- out_rd  out  5  destination register
- out_illegal  out  1  funct was not a shift opcode

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0, so out_valid=0.
  - out_result=0, out_rd=0, out_illegal=0.
  - in_ready=1 as soon as reset deasserts.
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Stage 1 capture:
  - op select: SLL=000000, SRL=000010, SRA=000011, SLLV=000100, SRLV=000110, SRAV=000111.
  - amount = funct[2] ? in_rs[4:0] : in_shamt.
  - Captured with in_rt, in_rd and an illegal flag.
- Stage 2 capture:
  - shift_core(value, amount, op) result, rd and illegal registered.
- Advance logic:
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv. This is combinational from out_ready; no combinational path from in_valid.
- Timing:
  - Latency: 2 cycles from input transfer to out_valid when there is no backpressure.
  - Throughput: 1 per cycle.
- Backpressure:
  - While out_ready=0 with both stages full, in_ready=0.
  - out_result, out_rd and out_illegal hold stable while out_valid=1 and out_ready=0.
- Illegal funct: out_result=0 and out_illegal=1. The entry still flows through and is never dropped.
- rd==0: out_result is forced to 0 ($zero). out_illegal is unaffected.
- Shift semantics:
  - amount 0 passes value through unchanged for all ops.
  - Amount 31 is legal.
  - SRA/SRAV fill with value[31].
  - Only rs[4:0] is used; rs[31:5] is ignored.
- Simultaneous input and output transfer with both stages full: the pipeline shifts by one and no bubble is inserted.
- Reset mid-operation: all in-flight entries are discarded and no output transfer occurs. Upstream must re-issue.
- Ordering: outputs emerge in strict input order.

Decomposition:
- Shared package shift_pkg:
  - funct localparams: FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV.
  - 2-bit op encoding: OP_SLL=0, OP_SRL=1, OP_SRA=2.
- Sub-module shift_core: combinational 32-bit barrel shifter.
  - Five log stages: 1, 2, 4, 8, 16.
  - Per-stage fill bit = (op==OP_SRA) ? value[31] : 0.
  - Left/right direction selected per stage.
  - Instantiated once between stage 1 and stage 2.

Test Plan:
- SRL: rt=32'h8000_0001, shamt=1, rd=3, out_ready=1 -> 2 cycles later out_valid=1, out_result=32'h4000_0000, out_rd=3.
- SRAV: rs=32'hFFFF_FFE4 (amount 4), rt=32'hF000_0000 -> out_result=32'hFF00_0000. SLLV with the same operands -> 32'h0000_0000.
- Backpressure: 4 back-to-back SLL (rt=1, shamt 0,1,2,3) with out_ready=0 for cycles 2-6.
  - in_ready drops after 2 entries.
  - On release, results 1, 2, 4, 8 appear in order with none lost.
  - Outputs stay stable while stalled.
- Illegal funct=6'b100000, rt=32'h1234 -> out_illegal=1, out_result=0. A following SRL with shamt=31 on rt=32'hFFFF_FFFF -> out_result=1, out_illegal=0.
- rd=0 with SLL rt=5 shamt=2 -> out_result=0.
- Reset mid-operation: assert rst_n=0 with 2 entries in flight -> out_valid=0 immediately and no stale result after release.

Source files
------------

// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the MIPS shift execute stage: funct codes, the
// internal shift-op encoding, pipeline entry layouts and the funct decoder.
package shift_pkg;

   localparam int XLEN = 32;
   localparam int AMTW = 5;

   // MIPS funct codes of the six shift instructions
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;
   localparam logic [5:0] FN_SLLV = 6'b000100;
   localparam logic [5:0] FN_SRLV = 6'b000110;
   localparam logic [5:0] FN_SRAV = 6'b000111;

   typedef enum logic [1:0] {
      OP_SLL = 2'd0,
      OP_SRL = 2'd1,
      OP_SRA = 2'd2
   } shift_op_e;

   typedef struct packed {
      shift_op_e op;
      logic      legal;
   } decode_t;

   // Stage 1 holds the operands of a decoded instruction
   typedef struct packed {
      logic [XLEN-1:0] value;
      logic [AMTW-1:0] amount;
      shift_op_e       op;
      logic [4:0]      rd;
      logic            illegal;
   } s1_entry_t;

   // Stage 2 holds the finished writeback payload
   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [4:0]      rd;
      logic            illegal;
   } s2_entry_t;

   // Map a funct field onto the shift op; non-shift functs come back illegal
   function automatic decode_t decode_funct(input logic [5:0] funct);
      decode_t d;
      d.op    = OP_SLL;
      d.legal = 1'b1;
      unique case (funct)
         FN_SLL, FN_SLLV: d.op = OP_SLL;
         FN_SRL, FN_SRLV: d.op = OP_SRL;
         FN_SRA, FN_SRAV: d.op = OP_SRA;
         default:         d.legal = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/shift_exec_stage_core.sv
// Combinational 32-bit logarithmic barrel shifter. Each of the five stages
// shifts by 1, 2, 4, 8 or 16 when the matching amount bit is set; right
// shifts fill with the sign bit for arithmetic shifts and zero otherwise.
module shift_core
   import shift_pkg::*;
(
   input  logic [XLEN-1:0] value,
   input  logic [AMTW-1:0] amount,
   input  shift_op_e       op,
   output logic [XLEN-1:0] result
);

   logic [XLEN-1:0] stage [0:AMTW];
   logic            fill;
   logic            left;

   assign fill     = (op == OP_SRA) ? value[XLEN-1] : 1'b0;
   assign left     = (op == OP_SLL);
   assign stage[0] = value;

   for (genvar i = 0; i < AMTW; i++) begin : g_stage
      localparam int SH = 1 << i;
      assign stage[i+1] = !amount[i] ? stage[i] :
                          left       ? {stage[i][XLEN-1-SH:0], {SH{1'b0}}} :
                                       {{SH{fill}}, stage[i][XLEN-1:SH]};
   end

   assign result = stage[AMTW];

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage elastic execute stage for MIPS shifts. Stage 1 latches the
// decoded op, the selected shift amount and the operand; stage 2 latches the
// barrel-shifted result. Valid/ready on both sides; in_ready depends on
// out_ready and pipeline occupancy only, never on in_valid.
module shift_exec_stage
   import shift_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [5:0]    in_funct,
   input  logic [4:0]    in_shamt,
   input  logic [DW-1:0] in_rs,
   input  logic [DW-1:0] in_rt,
   input  logic [4:0]    in_rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_result,
   output logic [4:0]    out_rd,
   output logic          out_illegal
);

   s1_entry_t     s1_q;
   s1_entry_t     s1_d;
   logic          s1_valid;
   s2_entry_t     s2_q;
   s2_entry_t     s2_d;
   logic          s2_valid;
   logic          s2_adv;
   logic          in_fire;
   logic          out_fire;
   decode_t       dec;
   logic [XLEN-1:0] shift_result;
   // Variable shifts only look at rs[4:0]; the upper bits are intentionally dropped
   logic          unused_rs_hi;

   assign unused_rs_hi = ^in_rs[DW-1:AMTW];

   // Handshake: stage 2 refills when empty or draining; stage 1 then frees up
   assign s2_adv   = s1_valid & (~s2_valid | out_ready);
   assign in_ready = ~s1_valid | s2_adv;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = s2_valid & out_ready;

   // Decode funct and select the shift amount for the incoming instruction
   // NOTE: every field gets a value on every path so no latch is inferred.
   always_comb begin
      dec          = decode_funct(in_funct);
      s1_d.value   = in_rt;
      s1_d.amount  = in_funct[2] ? in_rs[AMTW-1:0] : in_shamt;
      s1_d.op      = dec.op;
      s1_d.rd      = in_rd;
      s1_d.illegal = ~dec.legal;
   end

   shift_core u_shift_core (
      .value  (s1_q.value),
      .amount (s1_q.amount),
      .op     (s1_q.op),
      .result (shift_result)
   );

   // Build the writeback payload; illegal ops and writes to $zero yield 0
   always_comb begin
      s2_d         = '0;
      s2_d.rd      = s1_q.rd;
      s2_d.illegal = s1_q.illegal;
      if (!s1_q.illegal && (s1_q.rd != 5'd0)) begin
         s2_d.result = shift_result;
      end
   end

   // Stage 1 register: load on input transfer, empty when handed to stage 2
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else begin
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
         end else if (s2_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2 register: load from stage 1, empty on output transfer
   // NOTE: payload is reset too, because the outputs must read 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_q     <= '0;
      end else begin
         if (s2_adv) begin
            s2_valid <= 1'b1;
            s2_q     <= s2_d;
         end else if (out_fire) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = s2_valid;
   assign out_result  = s2_q.result;
   assign out_rd      = s2_q.rd;
   assign out_illegal = s2_q.illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: a queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then
// randomized traffic with random backpressure.
module tb_shift_exec_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_funct;
   logic [4:0]  in_shamt;
   logic [31:0] in_rs;
   logic [31:0] in_rt;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        illegal;
      int          acc;
   } exp_t;

   exp_t q[$];

   shift_exec_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_funct    (in_funct),
      .in_shamt    (in_shamt),
      .in_rs       (in_rs),
      .in_rt       (in_rt),
      .in_rd       (in_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
   endtask

   // Reference semantics straight from the instruction definitions
   function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [4:0] rd);
      exp_t e;
      int   amt;
      amt       = f[2] ? int'(rs[4:0]) : int'(sh);
      e.rd      = rd;
      e.illegal = 1'b0;
      e.acc     = 0;
      case (f)
         6'd0, 6'd4: e.result = rt << amt;
         6'd2, 6'd6: e.result = rt >> amt;
         6'd3, 6'd7: e.result = $unsigned($signed(rt) >>> amt);
         default: begin
            e.result  = 32'h0;
            e.illegal = 1'b1;
         end
      endcase
      if (rd == 5'd0) e.result = 32'h0;
      return e;
   endfunction

   // Reset discards everything in flight
   always @(negedge rst_n) q.delete();

   // Every-cycle compare against the model, sampled mid-cycle
   initial begin
      logic        prev_stall;
      logic [31:0] prev_result;
      logic [4:0]  prev_rd;
      logic        prev_ill;
      exp_t        e;
      prev_stall = 1'b0;
      prev_result = '0;
      prev_rd = '0;
      prev_ill = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            check("m_in_ready", in_ready, (q.size() < 2) || out_ready);
            check("m_out_valid", out_valid, (q.size() > 0) && (cyc >= q[0].acc + 2));
            if (prev_stall) begin
               check("m_hold_valid", out_valid, 1'b1);
               check("m_hold_result", out_result, prev_result);
               check("m_hold_rd", out_rd, prev_rd);
               check("m_hold_illegal", out_illegal, prev_ill);
            end
            if (out_valid && q.size() > 0) begin
               check("m_result", out_result, q[0].result);
               check("m_rd", out_rd, q[0].rd);
               check("m_illegal", out_illegal, q[0].illegal);
            end
            prev_stall  = out_valid && !out_ready;
            prev_result = out_result;
            prev_rd     = out_rd;
            prev_ill    = out_illegal;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
               e     = model(in_funct, in_shamt, in_rs, in_rt, in_rd);
               e.acc = cyc;
               q.push_back(e);
            end
         end
      end
   end

   // Present one instruction and hold it until accepted
   task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [4:0] rd);
      int n;
      in_funct = f;
      in_shamt = sh;
      in_rs    = rs;
      in_rt    = rt;
      in_rd    = rd;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Wait for the next result and compare with literal values
   task automatic expect_out(input string name, input logic [31:0] r,
                             input logic [4:0] rd, input logic ill);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({name, "_result"}, out_result, r);
         check({name, "_rd"}, out_rd, rd);
         check({name, "_illegal"}, out_illegal, ill);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int drain;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_funct  = '0;
      in_shamt  = '0;
      in_rs     = '0;
      in_rt     = '0;
      in_rd     = '0;
      out_ready = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_result", out_result, 32'h0);
      check("rst_out_rd", out_rd, 5'd0);
      check("rst_out_illegal", out_illegal, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1 check("rst_in_ready", in_ready, 1'b1);

      // SRL with two-cycle latency
      send(6'b000010, 5'd1, 32'h0, 32'h8000_0001, 5'd3);
      @(negedge clk);
      check("srl_lat1_valid", out_valid, 1'b0);
      @(negedge clk);
      check("srl_lat2_valid", out_valid, 1'b1);
      check("srl_result", out_result, 32'h4000_0000);
      check("srl_rd", out_rd, 5'd3);
      @(posedge clk);
      #1;

      // Variable shifts take the amount from rs[4:0] only
      send(6'b000111, 5'd9, 32'hFFFF_FFE4, 32'hF000_0000, 5'd5);
      expect_out("srav", 32'hFF00_0000, 5'd5, 1'b0);
      send(6'b000100, 5'd9, 32'hFFFF_FFE4, 32'hF000_0000, 5'd5);
      expect_out("sllv", 32'h0000_0000, 5'd5, 1'b0);

      // Illegal funct flows through, then a max-amount SRL
      send(6'b100000, 5'd0, 32'h0, 32'h0000_1234, 5'd7);
      expect_out("illegal", 32'h0, 5'd7, 1'b1);
      send(6'b000010, 5'd31, 32'h0, 32'hFFFF_FFFF, 5'd8);
      expect_out("srl31", 32'h1, 5'd8, 1'b0);
      send(6'b000011, 5'd31, 32'h0, 32'h8000_0000, 5'd9);
      expect_out("sra31", 32'hFFFF_FFFF, 5'd9, 1'b0);

      // Destination $zero forces a zero result
      send(6'b000000, 5'd2, 32'h0, 32'h5, 5'd0);
      expect_out("rd_zero", 32'h0, 5'd0, 1'b0);

      // Backpressure: two entries fill the stage, then it drains in order
      out_ready = 1'b0;
      send(6'b000000, 5'd0, 32'h0, 32'h1, 5'd10);
      send(6'b000000, 5'd1, 32'h0, 32'h1, 5'd11);
      in_valid = 1'b1;
      in_funct = 6'b000000;
      in_shamt = 5'd2;
      in_rt    = 32'h1;
      in_rd    = 5'd12;
      repeat (3) begin
         @(negedge clk);
         check("bp_in_ready", in_ready, 1'b0);
         check("bp_out_result", out_result, 32'h1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      out_ready = 1'b1;
      fork
         begin
            send(6'b000000, 5'd2, 32'h0, 32'h1, 5'd12);
            send(6'b000000, 5'd3, 32'h0, 32'h1, 5'd13);
         end
         begin
            expect_out("bp0", 32'h1, 5'd10, 1'b0);
            expect_out("bp1", 32'h2, 5'd11, 1'b0);
            expect_out("bp2", 32'h4, 5'd12, 1'b0);
            expect_out("bp3", 32'h8, 5'd13, 1'b0);
         end
      join

      // Reset with two entries in flight
      out_ready = 1'b0;
      send(6'b000000, 5'd4, 32'h0, 32'h3, 5'd14);
      send(6'b000000, 5'd5, 32'h0, 32'h3, 5'd15);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_result", out_result, 32'h0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("no_stale_valid", out_valid, 1'b0);
      end

      // Randomized traffic with random backpressure
      for (int i = 0; i < 1500; i++) begin
         int sel;
         @(posedge clk);
         #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         sel = $urandom_range(0, 7);
         case (sel)
            0: in_funct = 6'b000000;
            1: in_funct = 6'b000010;
            2: in_funct = 6'b000011;
            3: in_funct = 6'b000100;
            4: in_funct = 6'b000110;
            5: in_funct = 6'b000111;
            default: in_funct = 6'($urandom);
         endcase
         in_shamt = 5'($urandom);
         in_rs    = $urandom;
         in_rt    = $urandom;
         in_rd    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain = 0;
      while (q.size() > 0 && drain < 50) begin
         @(posedge clk);
         drain++;
      end
      check("drain_empty", q.size(), 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
